// File: rtl/alu_exec_unit.sv
// Execution-side ALU: single-cycle add/sub/logic ops and iterative one-bit-per-cycle
// shifts, behind valid/ready handshakes on both the request and the result side.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             negative_q, negative_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             shr_q, shr_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  logic             accept;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_sum;
  logic             add_ovf;
  logic             sub_ovf;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] shifted;

  assign in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept    = in_valid && in_ready;

  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign negative  = negative_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;

  // Arithmetic datapath on the live inputs; used only on the accept edge.
  always_comb begin
    add_sum = {1'b0, src_a} + {1'b0, src_b};
    sub_sum = {1'b0, src_a} + {1'b0, ~src_b} + {{WIDTH{1'b0}}, 1'b1};
    add_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (add_sum[WIDTH-1] != src_a[WIDTH-1]);
    sub_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (sub_sum[WIDTH-1] != src_a[WIDTH-1]);
    shamt   = src_b[SHW-1:0];
    if (shr_q) begin
      shifted = {1'b0, result_q[WIDTH-1:1]};
    end else begin
      shifted = {result_q[WIDTH-2:0], 1'b0};
    end
  end

  // Next-state and next-result logic; result_q doubles as the shift working register.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    shr_d      = shr_q;
    cnt_d      = cnt_q;
    if (accept) begin
      carry_d    = 1'b0;
      overflow_d = 1'b0;
      state_d    = DONE;
      case (alu_control)
        3'b000, 3'b011: begin
          result_d   = add_sum[WIDTH-1:0];
          carry_d    = add_sum[WIDTH];
          overflow_d = add_ovf;
        end
        3'b010: begin
          result_d   = sub_sum[WIDTH-1:0];
          carry_d    = sub_sum[WIDTH];
          overflow_d = sub_ovf;
        end
        3'b100: begin
          result_d = src_a ^ src_b;
        end
        3'b110: begin
          result_d = src_a | src_b;
        end
        3'b111: begin
          result_d = src_a & src_b;
        end
        3'b001, 3'b101: begin
          result_d = src_a;
          shr_d    = alu_control[2];
          cnt_d    = shamt;
          if (shamt != {SHW{1'b0}}) begin
            state_d = SHIFT;
          end else begin
            state_d = DONE;
          end
        end
        default: begin
          result_d = add_sum[WIDTH-1:0];
        end
      endcase
    end else begin
      case (state_q)
        SHIFT: begin
          result_d = shifted;
          cnt_d    = cnt_q - {{(SHW-1){1'b0}}, 1'b1};
          if (cnt_q == {{(SHW-1){1'b0}}, 1'b1}) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
          end
        end
        IDLE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    zero_d     = (result_d == {WIDTH{1'b0}});
    negative_d = result_d[WIDTH-1];
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      result_q   <= {WIDTH{1'b0}};
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      shr_q      <= 1'b0;
      cnt_q      <= {SHW{1'b0}};
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      shr_q      <= shr_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit; expected values are hand-computed constants.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_control;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        negative;
  logic        carry;
  logic        overflow;

  int n_cmp;
  int n_bad;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .negative(negative),
    .carry(carry), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single edge (caller guarantees in_ready).
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_control = op;
    src_a       = a;
    src_b       = b;
    in_valid    = 1'b1;
    tick();
    in_valid    = 1'b0;
    src_a       = 32'hxxxx_xxxx;
    src_b       = 32'hxxxx_xxxx;
  endtask

  // Cycles from accept edge until out_valid, bounded.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  function automatic logic [3:0] flags();
    return {zero, negative, carry, overflow};
  endfunction

  int lat;
  int seen;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    alu_control = 3'b000;
    src_a = 32'h0000_0000;
    src_b = 32'h0000_0000;
    tick();
    tick();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_flags", {60'd0, flags()}, 64'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", {63'd0, in_ready}, 64'd1);

    send(3'b000, 32'h7FFF_FFFF, 32'h0000_0001);
    check("add_ovf_valid", {63'd0, out_valid}, 64'd1);
    check("add_ovf_result", {32'd0, result}, 64'h8000_0000);
    check("add_ovf_flags", {60'd0, flags()}, 64'b0101);
    tick();
    check("add_retire_valid", {63'd0, out_valid}, 64'd0);

    send(3'b000, 32'hFFFF_FFFF, 32'h0000_0001);
    check("add_carry_result", {32'd0, result}, 64'h0);
    check("add_carry_flags", {60'd0, flags()}, 64'b1010);
    tick();

    send(3'b010, 32'd5, 32'd5);
    check("sub_eq_result", {32'd0, result}, 64'h0);
    check("sub_eq_flags", {60'd0, flags()}, 64'b1010);
    tick();

    send(3'b010, 32'd3, 32'd5);
    check("sub_neg_result", {32'd0, result}, 64'hFFFF_FFFE);
    check("sub_neg_flags", {60'd0, flags()}, 64'b0100);
    tick();

    send(3'b001, 32'h0000_0001, 32'h0000_0023);
    check("shl_busy_ready", {63'd0, in_ready}, 64'd0);
    wait_valid(lat);
    check("shl_latency", 64'(lat), 64'd4);
    check("shl_result", {32'd0, result}, 64'h0000_0008);
    check("shl_flags", {60'd0, flags()}, 64'b0000);
    tick();

    send(3'b101, 32'h8000_0000, 32'd31);
    wait_valid(lat);
    check("shr_latency", 64'(lat), 64'd32);
    check("shr_result", {32'd0, result}, 64'h0000_0001);
    tick();

    send(3'b101, 32'hF000_0000, 32'd4);
    wait_valid(lat);
    check("shr_zero_fill", {32'd0, result}, 64'h0F00_0000);
    tick();

    out_ready = 1'b0;
    send(3'b111, 32'hF0F0_F0F0, 32'hFF00_FF00);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {63'd0, out_valid}, 64'd1);
      check("bp_result", {32'd0, result}, 64'hF000_F000);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      tick();
    end
    check("bp_flags", {60'd0, flags()}, 64'b0100);
    out_ready = 1'b1;
    #1;
    check("b2b_in_ready", {63'd0, in_ready}, 64'd1);
    send(3'b110, 32'h0000_0001, 32'h0000_0002);
    check("b2b_valid", {63'd0, out_valid}, 64'd1);
    check("b2b_result", {32'd0, result}, 64'h0000_0003);
    tick();
    check("b2b_retire", {63'd0, out_valid}, 64'd0);

    send(3'b001, 32'hDEAD_BEEF, 32'd32);
    check("shamt0_valid", {63'd0, out_valid}, 64'd1);
    check("shamt0_result", {32'd0, result}, 64'hDEAD_BEEF);
    check("shamt0_flags", {60'd0, flags()}, 64'b0100);
    tick();

    send(3'b011, 32'd2, 32'd3);
    check("code011_result", {32'd0, result}, 64'd5);
    check("code011_flags", {60'd0, flags()}, 64'b0000);
    tick();

    send(3'b001, 32'h0000_0001, 32'd20);
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("abort_in_ready", {63'd0, in_ready}, 64'd1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("abort_no_valid", 64'(seen), 64'd0);

    send(3'b100, 32'hFFFF_0000, 32'h0000_FFFF);
    check("xor_valid", {63'd0, out_valid}, 64'd1);
    check("xor_result", {32'd0, result}, 64'hFFFF_FFFF);
    check("xor_flags", {60'd0, flags()}, 64'b0100);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
